// File: rtl/if_mem_resp_if.sv
// Fetch-request / instruction-RAM bundle between the PC stage, the fetch responder and the byte-wide RAM.
interface if_mem_resp_if;
  logic        ce_i;
  logic [31:0] pc_i;
  logic        branch_flag_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stall_req_o;

  modport slave (
    input  ce_i, pc_i, branch_flag_i, mem_din_i,
    output mem_a_o, mem_wr_o, inst_o, inst_valid_o, stall_req_o
  );

  modport master (
    output ce_i, pc_i, branch_flag_i, mem_din_i,
    input  mem_a_o, mem_wr_o, inst_o, inst_valid_o, stall_req_o
  );
endinterface

// File: rtl/if_mem_resp.sv
// Instruction-fetch responder: reads 4 little-endian bytes from a byte-wide RAM and returns a 32-bit word.
// Optional one-entry last-fetch shortcut enabled by defining IF_LASTHIT_EN.
module if_mem_resp #(
  parameter int MEM_ADDR_WIDTH = 17
) (
  input logic          clk,
  input logic          rst,
  if_mem_resp_if.slave bus
);

  localparam logic [31:0] ADDR_MASK = (32'd1 << MEM_ADDR_WIDTH) - 32'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  cnt_r;
  logic [31:0] addr_q_r;
  logic [31:0] inst_r;
  logic [23:0] bytes_r;
  logic        accept_s, hit_s, last_s;
  logic [31:0] word_s;

`ifdef IF_LASTHIT_EN
  logic        hit_v_r;
  logic [31:0] hit_addr_r;
  logic [31:0] hit_inst_r;

  assign hit_s = hit_v_r && (bus.pc_i == hit_addr_r);
`else
  assign hit_s = 1'b0;
`endif

  assign accept_s = (state_r == IDLE) && bus.ce_i && !bus.branch_flag_i;
  assign last_s   = (state_r == BUSY) && !bus.branch_flag_i && (cnt_r == 3'd4);
  // The top byte is still on the RAM data bus when the word is assembled.
  assign word_s   = {bus.mem_din_i, bytes_r};

  assign bus.mem_a_o      = ((state_r == BUSY) && (cnt_r < 3'd4)) ?
                            ((addr_q_r + {29'd0, cnt_r}) & ADDR_MASK) : 32'd0;
  assign bus.mem_wr_o     = 1'b0;
  assign bus.inst_o       = inst_r;
  assign bus.inst_valid_o = (state_r == DONE) && !bus.branch_flag_i;
  assign bus.stall_req_o  = accept_s || (state_r == BUSY);

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = hit_s ? DONE : BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (bus.branch_flag_i) begin
          state_s = IDLE;
        end else if (cnt_r == 3'd4) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, byte counter, address and assembled-instruction registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= 3'd0;
      addr_q_r <= 32'd0;
      inst_r   <= 32'd0;
      bytes_r  <= 24'd0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_q_r <= bus.pc_i;
        cnt_r    <= 3'd0;
`ifdef IF_LASTHIT_EN
        if (hit_s) begin
          inst_r <= hit_inst_r;
        end
`endif
      end else if (state_r == BUSY) begin
        if (bus.branch_flag_i) begin
          cnt_r <= 3'd0;
        end else begin
          // Data for address cnt-1 arrives while cnt is 1..3; shift it in from the top.
          if ((cnt_r != 3'd0) && (cnt_r != 3'd4)) begin
            bytes_r <= {bus.mem_din_i, bytes_r[23:8]};
          end
          if (last_s) begin
            inst_r <= word_s;
            cnt_r  <= 3'd0;
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
      end
    end
  end

`ifdef IF_LASTHIT_EN
  // Last-fetch tag, refreshed on every completed RAM fetch; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst) begin
      hit_v_r    <= 1'b0;
      hit_addr_r <= 32'd0;
      hit_inst_r <= 32'd0;
    end else if (last_s) begin
      hit_v_r    <= 1'b1;
      hit_addr_r <= addr_q_r;
      hit_inst_r <= word_s;
    end
  end
`endif

endmodule

// File: tb/tb_if_mem_resp.sv
// Randomized self-checking bench for if_mem_resp against a transaction-level fetch model.
module tb_if_mem_resp;
  localparam int          AW   = 17;
  localparam logic [31:0] MASK = 32'h0001_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] ram [0:131071];

  if_mem_resp_if bus();

  if_mem_resp #(.MEM_ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Read-only RAM with one cycle of read latency
  always @(posedge clk) bus.mem_din_i <= ram[bus.mem_a_o[16:0]];

  function automatic logic [31:0] addr_at(input logic [31:0] pc, input int k);
    return (pc + 32'(k)) & MASK;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    logic [31:0] a;
    logic [31:0] w;
    for (int b = 0; b < 4; b++) begin
      a = addr_at(pc, b);
      w[8*b +: 8] = ram[a[16:0]];
    end
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; bus.ce_i = 1'b0; bus.pc_i = $urandom; bus.branch_flag_i = 1'b0;
    tick; tick;
    @(negedge clk);
    total++; if (bus.mem_a_o !== 32'd0) begin bad++; $display("FAIL reset_mem_a: got %h want 0", bus.mem_a_o); end
    total++; if (bus.mem_wr_o !== 1'b0) begin bad++; $display("FAIL reset_mem_wr: got %b want 0", bus.mem_wr_o); end
    total++; if (bus.inst_o !== 32'd0) begin bad++; $display("FAIL reset_inst: got %h want 0", bus.inst_o); end
    total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.inst_valid_o); end
    total++; if (bus.stall_req_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall_req_o); end
    tick;
    rst = 1'b1;
  endtask

  task automatic test_fetch;
    logic [31:0] pcs [6];
    logic [31:0] exp_a;
    pcs[0] = 32'h0000_0000; pcs[1] = 32'h0001_FFFE; pcs[2] = 32'hFFFF_FFFE;
    pcs[3] = $urandom;      pcs[4] = $urandom;      pcs[5] = $urandom;
    for (int n = 0; n < 6; n++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 0) begin
          bus.ce_i = 1'b1; bus.pc_i = pcs[n]; bus.branch_flag_i = 1'b0;
        end else if (c < 7) begin
          bus.ce_i = 1'($urandom_range(0, 1)); bus.pc_i = $urandom;
        end else begin
          bus.ce_i = 1'b0;
        end
        @(negedge clk);
        exp_a = (c >= 1 && c <= 4) ? addr_at(pcs[n], c - 1) : 32'd0;
        total++; if (bus.mem_a_o !== exp_a) begin bad++; $display("FAIL fetch_mem_a pc=%h c=%0d: got %h want %h", pcs[n], c, bus.mem_a_o, exp_a); end
        total++; if (bus.stall_req_o !== (c <= 5)) begin bad++; $display("FAIL fetch_stall pc=%h c=%0d: got %b want %b", pcs[n], c, bus.stall_req_o, (c <= 5)); end
        total++; if (bus.inst_valid_o !== (c == 6)) begin bad++; $display("FAIL fetch_valid pc=%h c=%0d: got %b want %b", pcs[n], c, bus.inst_valid_o, (c == 6)); end
        total++; if (bus.mem_wr_o !== 1'b0) begin bad++; $display("FAIL fetch_mem_wr c=%0d: got %b want 0", c, bus.mem_wr_o); end
        if (c >= 6) begin
          total++; if (bus.inst_o !== word_at(pcs[n])) begin bad++; $display("FAIL fetch_inst pc=%h c=%0d: got %h want %h", pcs[n], c, bus.inst_o, word_at(pcs[n])); end
        end
        tick;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_a;
    logic        exp_v;
    for (int c = 0; c < 15; c++) begin
      if (c == 0) begin bus.ce_i = 1'b1; bus.pc_i = 32'h4; bus.branch_flag_i = 1'b0; end
      if (c == 1) bus.pc_i = 32'h8;
      if (c == 14) bus.ce_i = 1'b0;
      @(negedge clk);
      exp_v = (c == 6) || (c == 13);
      exp_a = (c >= 1 && c <= 4) ? addr_at(32'h4, c - 1) :
              (c >= 8 && c <= 11) ? addr_at(32'h8, c - 8) : 32'd0;
      total++; if (bus.inst_valid_o !== exp_v) begin bad++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, bus.inst_valid_o, exp_v); end
      total++; if (bus.stall_req_o !== (!exp_v && c != 14)) begin bad++; $display("FAIL b2b_stall c=%0d: got %b want %b", c, bus.stall_req_o, (!exp_v && c != 14)); end
      total++; if (bus.mem_a_o !== exp_a) begin bad++; $display("FAIL b2b_mem_a c=%0d: got %h want %h", c, bus.mem_a_o, exp_a); end
      if (exp_v) begin
        total++; if (bus.inst_o !== word_at(c == 6 ? 32'h4 : 32'h8)) begin bad++; $display("FAIL b2b_inst c=%0d: got %h want %h", c, bus.inst_o, word_at(c == 6 ? 32'h4 : 32'h8)); end
      end
      tick;
    end
  endtask

  task automatic test_flush;
    logic [31:0] p;
    logic [31:0] exp_a;
    p = $urandom;
    // flush in IDLE, then flush in BUSY at cnt=2 redirecting to 0x100
    for (int c = 0; c < 13; c++) begin
      if (c == 0) begin bus.ce_i = 1'b1; bus.pc_i = p; bus.branch_flag_i = 1'b1; end
      if (c == 1) bus.branch_flag_i = 1'b0;
      if (c == 4) begin bus.branch_flag_i = 1'b1; bus.pc_i = 32'h100; end
      if (c == 5) bus.branch_flag_i = 1'b0;
      if (c == 12) bus.ce_i = 1'b0;
      @(negedge clk);
      exp_a = (c >= 2 && c <= 4) ? addr_at(p, c - 2) :
              (c >= 6 && c <= 9) ? addr_at(32'h100, c - 6) : 32'd0;
      total++; if (bus.mem_a_o !== exp_a) begin bad++; $display("FAIL flush_mem_a c=%0d: got %h want %h", c, bus.mem_a_o, exp_a); end
      total++; if (bus.stall_req_o !== (c != 0 && c < 11)) begin bad++; $display("FAIL flush_stall c=%0d: got %b want %b", c, bus.stall_req_o, (c != 0 && c < 11)); end
      total++; if (bus.inst_valid_o !== (c == 11)) begin bad++; $display("FAIL flush_valid c=%0d: got %b want %b", c, bus.inst_valid_o, (c == 11)); end
      if (c == 11) begin
        total++; if (bus.inst_o !== word_at(32'h100)) begin bad++; $display("FAIL flush_inst: got %h want %h", bus.inst_o, word_at(32'h100)); end
      end
      tick;
    end
    // flush in DONE suppresses the pulse
    p = $urandom;
    for (int c = 0; c < 9; c++) begin
      if (c == 0) begin bus.ce_i = 1'b1; bus.pc_i = p; end
      if (c == 1) bus.ce_i = 1'b0;
      if (c == 6) bus.branch_flag_i = 1'b1;
      if (c == 7) bus.branch_flag_i = 1'b0;
      @(negedge clk);
      exp_a = (c >= 1 && c <= 4) ? addr_at(p, c - 1) : 32'd0;
      total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL done_flush_valid c=%0d: got %b want 0", c, bus.inst_valid_o); end
      total++; if (bus.stall_req_o !== (c <= 5)) begin bad++; $display("FAIL done_flush_stall c=%0d: got %b want %b", c, bus.stall_req_o, (c <= 5)); end
      total++; if (bus.mem_a_o !== exp_a) begin bad++; $display("FAIL done_flush_mem_a c=%0d: got %h want %h", c, bus.mem_a_o, exp_a); end
      tick;
    end
  endtask

  task automatic test_reset_midfetch;
    logic [31:0] p;
    logic [31:0] exp_a;
    p = $urandom;
    for (int c = 0; c < 13; c++) begin
      if (c == 0) begin bus.ce_i = 1'b1; bus.pc_i = p; bus.branch_flag_i = 1'b0; end
      if (c == 1) bus.ce_i = 1'b0;
      if (c == 4) rst = 1'b0;
      if (c == 5) rst = 1'b1;
      @(negedge clk);
      exp_a = (c >= 1 && c <= 4) ? addr_at(p, c - 1) : 32'd0;
      total++; if (bus.mem_a_o !== exp_a) begin bad++; $display("FAIL rst_mid_mem_a c=%0d: got %h want %h", c, bus.mem_a_o, exp_a); end
      total++; if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid c=%0d: got %b want 0", c, bus.inst_valid_o); end
      total++; if (bus.stall_req_o !== (c <= 4)) begin bad++; $display("FAIL rst_mid_stall c=%0d: got %b want %b", c, bus.stall_req_o, (c <= 4)); end
      if (c >= 5) begin
        total++; if (bus.inst_o !== 32'd0) begin bad++; $display("FAIL rst_mid_inst c=%0d: got %h want 0", c, bus.inst_o); end
      end
      tick;
    end
  endtask

  task automatic test_last_hit;
    logic [31:0] exp_a;
    logic        exp_v;
    logic        exp_s;
    for (int c = 0; c < 17; c++) begin
      if (c == 0) begin bus.ce_i = 1'b1; bus.pc_i = 32'h40; bus.branch_flag_i = 1'b0; end
      if (c == 1) bus.ce_i = 1'b0;
      if (c == 8) bus.ce_i = 1'b1;
      if (c == 9) bus.ce_i = 1'b0;
      @(negedge clk);
`ifdef IF_LASTHIT_EN
      exp_v = (c == 6) || (c == 9);
      exp_s = (c <= 5) || (c == 8);
      exp_a = (c >= 1 && c <= 4) ? addr_at(32'h40, c - 1) : 32'd0;
`else
      exp_v = (c == 6) || (c == 14);
      exp_s = (c <= 5) || (c >= 8 && c <= 13);
      exp_a = (c >= 1 && c <= 4) ? addr_at(32'h40, c - 1) :
              (c >= 9 && c <= 12) ? addr_at(32'h40, c - 9) : 32'd0;
`endif
      total++; if (bus.inst_valid_o !== exp_v) begin bad++; $display("FAIL repeat_valid c=%0d: got %b want %b", c, bus.inst_valid_o, exp_v); end
      total++; if (bus.stall_req_o !== exp_s) begin bad++; $display("FAIL repeat_stall c=%0d: got %b want %b", c, bus.stall_req_o, exp_s); end
      total++; if (bus.mem_a_o !== exp_a) begin bad++; $display("FAIL repeat_mem_a c=%0d: got %h want %h", c, bus.mem_a_o, exp_a); end
      if (exp_v) begin
        total++; if (bus.inst_o !== word_at(32'h40)) begin bad++; $display("FAIL repeat_inst c=%0d: got %h want %h", c, bus.inst_o, word_at(32'h40)); end
      end
      tick;
    end
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) ram[i] = 8'($urandom);
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'hA0; ram[3] = 8'h00;
    bus.ce_i = 1'b0; bus.pc_i = 32'd0; bus.branch_flag_i = 1'b0;
    rst = 1'b0;
    #1;
    test_reset;
    test_fetch;
    test_back_to_back;
    test_flush;
    test_reset_midfetch;
    test_last_hit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
